// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of the single-word data memory controller.
// Optional macro MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-break; default is fixed priority (A wins).
module mem_port_arbiter #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TO_WIDTH       = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_done,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_done,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  ctrl_rd_en,
  output logic                  ctrl_wr_en,
  output logic [ADDR_WIDTH-1:0] ctrl_addr,
  output logic [DATA_WIDTH-1:0] ctrl_wdata,
  input  logic [DATA_WIDTH-1:0] ctrl_rdata,
  input  logic                  ctrl_rvalid,
  input  logic                  ctrl_busy,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic                  owner_q, owner_d;   // 0 = port A, 1 = port B
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [TO_WIDTH-1:0]   wd_q, wd_d;
  logic                  a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic                  a_done_q, a_done_d, b_done_q, b_done_d;
  logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic                  rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic                  timeout_q, timeout_d;

  logic pick_b;
  logic any_req;
  logic waiting;
  logic wd_expired;
  logic rd_hit;
  logic wr_hit;
  logic go;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic rr_q, rr_d;   // owner of the most recent ISSUE; 1 = B

  always_comb pick_b = b_req & (~a_req | ~rr_q);

  always_comb begin
    rr_d = rr_q;
    if (state_q == ISSUE) rr_d = owner_q;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_q <= 1'b1;
    else     rr_q <= rr_d;
  end
`else
  always_comb pick_b = b_req & ~a_req;
`endif

  always_comb begin
    any_req    = a_req | b_req;
    waiting    = (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);
    wd_expired = waiting && (wd_q == TO_WIDTH'(TIMEOUT_CYCLES - 1));
    rd_hit     = (state_q == WAIT_DONE) && !we_q && ctrl_rvalid;
    wr_hit     = (state_q == WAIT_DONE) && we_q && !ctrl_busy;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a completion in the same cycle as expiry wins over the abort
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!ctrl_busy && any_req) state_d = ISSUE;
      ISSUE:     state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (wd_expired)     state_d = IDLE;
        else if (ctrl_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (rd_hit || wr_hit || wd_expired) state_d = IDLE;
      end
      default:   state_d = IDLE;
    endcase
  end

  // Output / datapath logic feeding the registered outputs
  always_comb begin
    go        = (state_q == IDLE) && (state_d == ISSUE);
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    a_gnt_d   = 1'b0;
    b_gnt_d   = 1'b0;
    rd_en_d   = 1'b0;
    wr_en_d   = 1'b0;
    a_done_d  = (rd_hit | wr_hit) & ~owner_q;
    b_done_d  = (rd_hit | wr_hit) &  owner_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    timeout_d = wd_expired & ~(rd_hit | wr_hit);

    if (go) begin
      owner_d = pick_b;
      we_d    = pick_b ? b_we    : a_we;
      addr_d  = pick_b ? b_addr  : a_addr;
      wdata_d = pick_b ? b_wdata : a_wdata;
      a_gnt_d = ~pick_b;
      b_gnt_d =  pick_b;
      rd_en_d = ~we_d;
      wr_en_d =  we_d;
    end

    if (rd_hit) begin
      if (owner_q) b_rdata_d = ctrl_rdata;
      else         a_rdata_d = ctrl_rdata;
    end

    // Watchdog restarts on every state change so each wait state gets a fresh budget
    if (state_d != state_q) wd_d = '0;
    else if (waiting)       wd_d = wd_q + TO_WIDTH'(1);
    else                    wd_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q      <= 1'b0;
      owner_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wd_q      <= '0;
      a_gnt_q   <= 1'b0;
      b_gnt_q   <= 1'b0;
      a_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      we_q      <= we_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wd_q      <= wd_d;
      a_gnt_q   <= a_gnt_d;
      b_gnt_q   <= b_gnt_d;
      a_done_q  <= a_done_d;
      b_done_q  <= b_done_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      timeout_q <= timeout_d;
    end
  end

  assign a_gnt       = a_gnt_q;
  assign b_gnt       = b_gnt_q;
  assign a_done      = a_done_q;
  assign b_done      = b_done_q;
  assign a_rdata     = a_rdata_q;
  assign b_rdata     = b_rdata_q;
  assign ctrl_rd_en  = rd_en_q;
  assign ctrl_wr_en  = wr_en_q;
  assign ctrl_addr   = addr_q;
  assign ctrl_wdata  = wdata_q;
  assign timeout_err = timeout_q;

endmodule
